// File: rtl/dark_irq_timer.sv
// -----------------------------------------------------------------------------
// dark_irq_timer
//   Multi-channel timer / interrupt controller for the darksocv IO space.
//   CHANNELS independent down-counters share one prescaler. Each channel runs
//   periodic or one-shot. On expiry it sets its pending flag. The flags are
//   masked by ENABLE and ORed into a single registered IRQ line. STATUS is
//   write-1-to-clear.
//
//   Register map (word index):
//     0          STATUS    R: pending bits   W: 1 clears bit n
//     1          ENABLE    R/W IRQ mask
//     2          PRESCALE  R/W tick every PRESCALE+1 cycles
//     3          reserved (reads 0)
//     4(n+1)+0   RELOAD[n] R/W
//     4(n+1)+1   COUNT[n]  RO
//     4(n+1)+2   CTRL[n]   R/W bit0 RUN, bit1 ONESHOT
//     4(n+1)+3   reserved (reads 0)
//     Unmapped channel slots read 0.
//
// Ports
//   clk    in   system clock, rising edge
//   res    in   asynchronous active-high reset
//   addr   in   word address (byte address bits [AW+1:2])
//   rd     in   read strobe (one cycle)
//   wr     in   write strobe (one cycle)
//   be     in   byte enables for wr
//   datai  in   write data
//   datao  out  registered read data, held until the next read
//   ack    out  pulses one cycle after rd or wr
//   pend   out  raw per-channel pending flags
//   irq    out  registered |(pend & enable)
// -----------------------------------------------------------------------------
module dark_irq_timer #(
  parameter int          CHANNELS = 4,
  parameter int          WIDTH    = 32,
  parameter logic [31:0] PSC_RST  = 32'd0,
  parameter int          AW       = $clog2(CHANNELS + 1) + 2
) (
  input  logic                clk,
  input  logic                res,
  input  logic [AW-1:0]       addr,
  input  logic                rd,
  input  logic                wr,
  input  logic [3:0]          be,
  input  logic [31:0]         datai,
  output logic [31:0]         datao,
  output logic                ack,
  output logic [CHANNELS-1:0] pend,
  output logic                irq
);

  localparam logic [AW-1:0] A_STATUS   = AW'(0);
  localparam logic [AW-1:0] A_ENABLE   = AW'(1);
  localparam logic [AW-1:0] A_PRESCALE = AW'(2);

  logic [CHANNELS-1:0] enable;
  logic [WIDTH-1:0]    prescale;
  logic [WIDTH-1:0]    psc;
  logic                tick;

  logic [WIDTH-1:0]    reload [CHANNELS];
  logic [WIDTH-1:0]    count  [CHANNELS];
  logic [CHANNELS-1:0] run;
  logic [CHANNELS-1:0] oneshot;

  logic [31:0]         wmask;
  logic [CHANNELS-1:0] reload_we;
  logic [CHANNELS-1:0] ctrl_we;
  logic [CHANNELS-1:0] start;
  logic [CHANNELS-1:0] stop;
  logic [CHANNELS-1:0] expire;
  logic [CHANNELS-1:0] clr;
  logic [31:0]         rdata;

  assign wmask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  assign tick  = (psc == '0);

  // Per-channel control decode.
  // NOTE: every variable driven here gets a default first; otherwise a path
  // that skips an assignment would make synthesis infer a latch.
  always_comb begin
    reload_we = '0;
    ctrl_we   = '0;
    start     = '0;
    stop      = '0;
    expire    = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      reload_we[n] = wr && (addr == AW'(4 * (n + 1)));
      ctrl_we[n]   = wr && (addr == AW'(4 * (n + 1) + 2));
      // A RUN 0->1 write loads COUNT from RELOAD instead of a tick step.
      start[n]     = ctrl_we[n] && be[0] && datai[0] && !run[n];
      // A RUN ->0 write freezes COUNT, even on a tick edge.
      stop[n]      = ctrl_we[n] && be[0] && !datai[0];
      expire[n]    = tick && run[n] && !stop[n] && (count[n] == '0);
    end
    // The W1C mask is applied before expire is ORed in, so a set on the
    // same edge as a clear wins.
    clr = (wr && addr == A_STATUS) ?
          (datai[CHANNELS-1:0] & wmask[CHANNELS-1:0]) : '0;
  end

  // Read mux. Any address not decoded below reads 0.
  always_comb begin
    rdata = '0;
    case (addr)
      A_STATUS:   rdata[CHANNELS-1:0] = pend;
      A_ENABLE:   rdata[CHANNELS-1:0] = enable;
      A_PRESCALE: rdata[WIDTH-1:0]    = prescale;
      default: begin
        for (int n = 0; n < CHANNELS; n++) begin
          if (addr == AW'(4 * (n + 1)))     rdata[WIDTH-1:0] = reload[n];
          if (addr == AW'(4 * (n + 1) + 1)) rdata[WIDTH-1:0] = count[n];
          if (addr == AW'(4 * (n + 1) + 2)) rdata[1:0]       = {oneshot[n], run[n]};
        end
      end
    endcase
  end

  // Bus side, global registers, prescaler and IRQ.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values. That is also why a read paired with a write
  // returns the old contents.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      datao    <= '0;
      ack      <= 1'b0;
      irq      <= 1'b0;
      pend     <= '0;
      enable   <= '0;
      prescale <= PSC_RST[WIDTH-1:0];
      psc      <= PSC_RST[WIDTH-1:0];
    end else begin
      ack <= rd | wr;
      if (rd) datao <= rdata;

      if (wr && addr == A_ENABLE)
        enable <= (enable & ~wmask[CHANNELS-1:0]) | (datai[CHANNELS-1:0] & wmask[CHANNELS-1:0]);
      // A new PRESCALE is only picked up when psc next reloads.
      if (wr && addr == A_PRESCALE)
        prescale <= (prescale & ~wmask[WIDTH-1:0]) | (datai[WIDTH-1:0] & wmask[WIDTH-1:0]);

      if (tick) psc <= prescale;
      else      psc <= psc - WIDTH'(1);

      pend <= (pend & ~clr) | expire;
      irq  <= |(pend & enable);
    end
  end

  // Channel counters.
  // NOTE: the per-channel arrays are ordinary flops with visible reset
  // values, not a RAM, so they are reset along with everything else.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      run     <= '0;
      oneshot <= '0;
      for (int n = 0; n < CHANNELS; n++) begin
        reload[n] <= '0;
        count[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (reload_we[n])
          reload[n] <= (reload[n] & ~wmask[WIDTH-1:0]) | (datai[WIDTH-1:0] & wmask[WIDTH-1:0]);

        if (ctrl_we[n] && be[0]) oneshot[n] <= datai[1];

        if (start[n]) begin
          run[n]   <= 1'b1;
          count[n] <= reload[n];
        end else if (stop[n]) begin
          run[n] <= 1'b0;
        end else if (tick && run[n]) begin
          if (count[n] != '0) begin
            count[n] <= count[n] - WIDTH'(1);
          end else if (oneshot[n]) begin
            run[n] <= 1'b0;
          end else begin
            count[n] <= reload[n];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dark_irq_timer.sv
// -----------------------------------------------------------------------------
// tb_dark_irq_timer
//   Directed bench for dark_irq_timer (CHANNELS=4, WIDTH=32, PSC_RST=7).
//   Inputs change on the falling edge. Outputs are sampled on the falling
//   edge, half a cycle after the rising edge that updates them.
// -----------------------------------------------------------------------------
module tb_dark_irq_timer;

  localparam int          CHANNELS = 4;
  localparam int          WIDTH    = 32;
  localparam int          AW       = 5;
  localparam logic [31:0] PSC_RST  = 32'd7;

  localparam logic [AW-1:0] A_STATUS   = 5'd0;
  localparam logic [AW-1:0] A_ENABLE   = 5'd1;
  localparam logic [AW-1:0] A_PRESCALE = 5'd2;
  localparam logic [AW-1:0] A_RSV      = 5'd3;

  logic                clk   = 1'b0;
  logic                res   = 1'b0;
  logic [AW-1:0]       addr  = '0;
  logic                rd    = 1'b0;
  logic                wr    = 1'b0;
  logic [3:0]          be    = '0;
  logic [31:0]         datai = '0;
  logic [31:0]         datao;
  logic                ack;
  logic [CHANNELS-1:0] pend;
  logic                irq;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dark_irq_timer #(
    .CHANNELS (CHANNELS),
    .WIDTH    (WIDTH),
    .PSC_RST  (PSC_RST)
  ) dut (
    .clk   (clk),
    .res   (res),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .be    (be),
    .datai (datai),
    .datao (datao),
    .ack   (ack),
    .pend  (pend),
    .irq   (irq)
  );

  function automatic logic [AW-1:0] ch_addr(input int n, input int k);
    return AW'(4 * (n + 1) + k);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; the write happens on the next rising edge and
  // the task returns on the falling edge after it.
  task automatic bus_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    datai = d;
    be    = b;
    wr    = 1'b1;
    @(negedge clk);
    wr = 1'b0;
    be = '0;
  endtask

  task automatic bus_read(input string tag, input logic [AW-1:0] a, input logic [31:0] exp);
    addr = a;
    rd   = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check(tag, datao, exp);
    check({tag, "_ack"}, {31'd0, ack}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;

    // ---------------- reset state (checked before any clock edge) ----------
    #2 res = 1'b1;
    #1;
    check("rst_datao", datao, 32'd0);
    check("rst_ack",   {31'd0, ack}, 32'd0);
    check("rst_irq",   {31'd0, irq}, 32'd0);
    check("rst_pend",  {28'd0, pend}, 32'd0);
    repeat (2) @(negedge clk);
    res = 1'b0;
    bus_read("rst_prescale", A_PRESCALE, PSC_RST);
    bus_read("rst_enable",   A_ENABLE,   32'd0);
    bus_read("rst_status",   A_STATUS,   32'd0);
    bus_read("rst_count0",   ch_addr(0, 1), 32'd0);
    bus_read("rst_ctrl0",    ch_addr(0, 2), 32'd0);
    bus_read("rsv_word3",    A_RSV,         32'd0);

    // ---------------- T1: periodic, PRESCALE=0, RELOAD0=3 -------------------
    bus_write(A_PRESCALE, 32'd0, 4'hF);
    repeat (10) @(negedge clk);          // let psc drain its reset value
    bus_write(ch_addr(0, 0), 32'd3, 4'hF);
    bus_write(A_ENABLE, 32'd1, 4'hF);
    bus_write(ch_addr(0, 2), 32'd1, 4'hF); // edge E0: COUNT0<=3
    check("t1_pend_e0", {28'd0, pend}, 32'd0);
    for (int i = 1; i <= 3; i++) begin   // E1..E3: 2,1,0
      @(negedge clk);
      check("t1_pend_quiet", {31'd0, pend[0]}, 32'd0);
    end
    @(negedge clk);                      // E4: expiry
    check("t1_pend_e4", {31'd0, pend[0]}, 32'd1);
    check("t1_irq_e4",  {31'd0, irq},     32'd0);
    @(negedge clk);                      // E5: IRQ one cycle later
    check("t1_irq_e5",  {31'd0, irq},     32'd1);
    bus_write(A_STATUS, 32'd1, 4'hF);    // E6: clear
    check("t1_pend_clr", {31'd0, pend[0]}, 32'd0);
    check("t1_irq_e6",   {31'd0, irq},     32'd1);
    @(negedge clk);                      // E7
    check("t1_pend_e7", {31'd0, pend[0]}, 32'd0);
    check("t1_irq_e7",  {31'd0, irq},     32'd0);
    @(negedge clk);                      // E8: next period expiry
    check("t1_pend_e8", {31'd0, pend[0]}, 32'd1);

    // ---------------- T3: W1C on the expiry edge -----------------------------
    repeat (3) @(negedge clk);           // E9..E11
    bus_write(A_STATUS, 32'd1, 4'hF);    // E12: expiry and clear together
    check("t3_set_wins", {31'd0, pend[0]}, 32'd1);
    bus_write(A_STATUS, 32'd1, 4'hF);    // E13: plain clear
    check("t3_pend_clr", {31'd0, pend[0]}, 32'd0);
    check("t3_irq_hold", {31'd0, irq},     32'd1);
    @(negedge clk);                      // E14
    check("t3_irq_drop", {31'd0, irq},     32'd0);
    bus_write(ch_addr(0, 2), 32'd0, 4'hF); // E15: stop, COUNT0 frozen at 1
    bus_read("t3_count_frozen", ch_addr(0, 1), 32'd1);
    check("t3_pend_stopped", {31'd0, pend[0]}, 32'd0);

    // ---------------- T2: one-shot, PRESCALE=1, RELOAD1=5 -------------------
    // PRESCALE write at P0 (psc reloads old 0), tick at P1, psc=1 at P2,
    // then ticks on P3,P5,...: count 5->0 by P11, expiry at P13 = 11 edges
    // after the CTRL write at P2.
    bus_write(A_PRESCALE, 32'd1, 4'hF);      // P0
    bus_write(ch_addr(1, 0), 32'd5, 4'hF);   // P1
    bus_write(ch_addr(1, 2), 32'd3, 4'hF);   // P2: RUN|ONESHOT
    cyc = 0;
    while (pend[1] == 1'b0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("t2_latency", cyc, 32'd11);
    check("t2_irq_masked", {31'd0, irq}, 32'd0);
    bus_read("t2_ctrl1",  ch_addr(1, 2), 32'd2);  // RUN cleared, ONESHOT kept
    bus_read("t2_count1", ch_addr(1, 1), 32'd0);
    check("t2_pend_once", {28'd0, pend}, 32'd2);

    // ---------------- T4: ENABLE gating -------------------------------------
    bus_write(A_ENABLE, 32'd0, 4'hF);
    bus_write(ch_addr(2, 2), 32'd3, 4'hF);   // RELOAD2=0 one-shot: expires on next tick
    repeat (4) @(negedge clk);
    check("t4_pend",     {28'd0, pend}, 32'h6);
    check("t4_irq_off",  {31'd0, irq},  32'd0);
    bus_write(A_ENABLE, 32'd4, 4'hF);
    check("t4_irq_lag",  {31'd0, irq},  32'd0);
    @(negedge clk);
    check("t4_irq_on",   {31'd0, irq},  32'd1);

    // ---------------- T5: byte enables, ACK, RD+WR, RO/unmapped -------------
    bus_write(ch_addr(3, 0), 32'hAABBCCDD, 4'b0001);
    check("t5_ack_pulse", {31'd0, ack}, 32'd1);
    @(negedge clk);
    check("t5_ack_once",  {31'd0, ack}, 32'd0);
    bus_read("t5_reload_be", ch_addr(3, 0), 32'h000000DD);
    addr  = ch_addr(3, 0);
    datai = 32'h11223344;
    be    = 4'hF;
    rd    = 1'b1;
    wr    = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    wr = 1'b0;
    be = '0;
    check("t5_rdwr_old", datao, 32'h000000DD);
    bus_read("t5_rdwr_new", ch_addr(3, 0), 32'h11223344);
    bus_write(ch_addr(3, 1), 32'h0000FFFF, 4'hF);
    bus_read("t5_count_ro",  ch_addr(3, 1), 32'd0);
    bus_read("t5_unmapped",  ch_addr(4, 0), 32'd0);
    bus_read("t5_ch_rsv",    ch_addr(0, 3), 32'd0);
    bus_read("t5_prescale",  A_PRESCALE,    32'd1);
    bus_read("t5_enable_be", A_ENABLE,      32'd4);

    // ---------------- T6: async reset mid-count and mid-access --------------
    bus_write(A_STATUS, 32'hF, 4'hF);
    check("t6_pend_clr", {28'd0, pend}, 32'd0);
    bus_write(A_ENABLE, 32'hF, 4'hF);
    bus_write(ch_addr(0, 2), 32'd1, 4'hF);   // restart ch0: COUNT0<=3
    repeat (12) @(negedge clk);
    check("t6_irq_pre", {31'd0, irq}, 32'd1);
    addr = ch_addr(0, 1);
    rd   = 1'b1;
    @(posedge clk);
    #2;
    check("t6_ack_pre", {31'd0, ack}, 32'd1);
    res = 1'b1;
    #1;
    check("t6_ack_async",   {31'd0, ack}, 32'd0);
    check("t6_pend_async",  {28'd0, pend}, 32'd0);
    check("t6_irq_async",   {31'd0, irq}, 32'd0);
    check("t6_datao_async", datao, 32'd0);
    rd = 1'b0;
    @(negedge clk);
    res = 1'b0;
    bus_read("t6_count0",   ch_addr(0, 1), 32'd0);
    bus_read("t6_ctrl0",    ch_addr(0, 2), 32'd0);
    bus_read("t6_prescale", A_PRESCALE,    PSC_RST);
    bus_read("t6_enable",   A_ENABLE,      32'd0);
    bus_read("t6_reload3",  ch_addr(3, 0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
